// File: rtl/ext_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_pipe: immediate extender with a 2-entry valid/ready output buffer |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int c_PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_data;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_tail;

  logic [OUT_W-1:0] r_data [2];
  logic [1:0]       r_err;
  logic             r_head;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_xfer;

  assign w_sext = {{c_PAD_W{imm[IN_W-1]}}, imm};

  always_comb begin
    w_data = '0;
    w_err  = 1'b0;
    case (eop)
      3'b000:  w_data = w_sext;
      3'b001:  w_data = {{c_PAD_W{1'b0}}, imm};
      3'b010:  w_data = {imm, {c_PAD_W{1'b0}}};
      3'b011:  w_data = w_sext << BR_SHIFT;
      3'b100:  w_data = {{c_PAD_W{1'b1}}, imm};
      default: w_err  = 1'b1;
    endcase
  end

  assign in_ready  = ~r_count[1];
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Write slot sits directly behind the head (count is 0 or 1 when pushing).
  assign w_tail    = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_err     <= '0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
      r_xfer    <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[w_tail] <= w_data;
        r_err[w_tail]  <= w_err;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        r_xfer <= r_xfer + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data = out_valid ? r_data[r_head] : '0;
  assign out_err  = out_valid & r_err[r_head];
  assign xfer_cnt = r_xfer;

endmodule
`default_nettype wire
